// File: rtl/counter_pkg.sv
// Shared encodings for the general-purpose up/down counter family.
// Saturation mode values and the direction encoding of the 'up' input.
package counter_pkg;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/counter_next.sv
// Next-state and terminal-count logic for sync_updown_counter.
// Purely combinational: limit compares, load clamp and wrap/saturate select.
module counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = CNT_WRAP
) (
  input  logic [WIDTH-1:0] out,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] nxt,
  output logic             tc
);

  // MODULUS-1 always fits in WIDTH bits, so the compares stay WIDTH wide.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic             SAT_ON  = (SATURATE == CNT_SAT);

  logic count_up;
  logic at_max;
  logic at_min;
  logic [WIDTH-1:0] load_clamped;

  assign count_up     = (up == DIR_UP);
  assign at_max       = (out == MAX_VAL);
  assign at_min       = (out == '0);
  assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  always_comb begin
    nxt = out;
    if (load) begin
      nxt = load_clamped;
    end else if (en) begin
      if (count_up) begin
        if (!at_max)     nxt = out + WIDTH'(1);
        else if (SAT_ON) nxt = out;
        else             nxt = '0;
      end else begin
        if (!at_min)     nxt = out - WIDTH'(1);
        else if (SAT_ON) nxt = out;
        else             nxt = MAX_VAL;
      end
    end
  end

  // Independent of saturation so a cascaded stage sees the limit either way.
  assign tc = en & ~load & ~rst & (count_up ? at_max : at_min);

endmodule

// File: rtl/sync_updown_counter.sv
// Parametrised synchronous up/down counter with load, wrap/saturate and
// a combinational terminal-count flag usable as the enable of a next stage.
module sync_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int SATURATE  = CNT_WRAP,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc
);

  if (WIDTH < 1 || WIDTH > 62) begin : g_bad_width
    $error("sync_updown_counter: WIDTH must be in 1..62");
  end
  if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("sync_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end
  if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
    $error("sync_updown_counter: RESET_VAL must be < MODULUS");
  end
  if (SATURATE != CNT_WRAP && SATURATE != CNT_SAT) begin : g_bad_saturate
    $error("sync_updown_counter: SATURATE must be CNT_WRAP or CNT_SAT");
  end

  localparam logic [WIDTH-1:0] RESET_CNT = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] nxt;

  counter_next #(
    .WIDTH    (WIDTH),
    .MODULUS  (MODULUS),
    .SATURATE (SATURATE)
  ) u_next (
    .out      (out),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .nxt      (nxt),
    .tc       (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) out <= RESET_CNT;
    else     out <= nxt;
  end

endmodule

// File: tb/tb_sync_updown_counter.sv
// Bench for sync_updown_counter: four configurations plus a two-digit cascade,
// directed sequences followed by random stimulus against an arithmetic model.
module tb_sync_updown_counter;

  localparam int NI = 4;
  localparam int WS   [NI] = '{4, 4, 4, 8};
  localparam int MODS [NI] = '{16, 10, 10, 256};
  localparam int SATS [NI] = '{0, 0, 1, 0};
  localparam int RVS  [NI] = '{0, 0, 0, 200};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s [NI];
  logic       en_s  [NI];
  logic       up_s  [NI];
  logic       ld_s  [NI];
  logic [7:0] lv_s  [NI];
  logic       tc_s  [NI];
  logic [3:0] o0, o1, o2;
  logic [7:0] o3;

  logic       rst_c, en_c;
  logic [3:0] lo, hi;
  logic       lo_tc, hi_tc;

  sync_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .RESET_VAL(0)) u0 (
    .clk(clk), .rst(rst_s[0]), .en(en_s[0]), .up(up_s[0]), .load(ld_s[0]),
    .load_val(lv_s[0][3:0]), .out(o0), .tc(tc_s[0]));
  sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RESET_VAL(0)) u1 (
    .clk(clk), .rst(rst_s[1]), .en(en_s[1]), .up(up_s[1]), .load(ld_s[1]),
    .load_val(lv_s[1][3:0]), .out(o1), .tc(tc_s[1]));
  sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .RESET_VAL(0)) u2 (
    .clk(clk), .rst(rst_s[2]), .en(en_s[2]), .up(up_s[2]), .load(ld_s[2]),
    .load_val(lv_s[2][3:0]), .out(o2), .tc(tc_s[2]));
  sync_updown_counter #(.WIDTH(8), .MODULUS(256), .SATURATE(0), .RESET_VAL(200)) u3 (
    .clk(clk), .rst(rst_s[3]), .en(en_s[3]), .up(up_s[3]), .load(ld_s[3]),
    .load_val(lv_s[3]), .out(o3), .tc(tc_s[3]));

  sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RESET_VAL(0)) u_lo (
    .clk(clk), .rst(rst_c), .en(en_c), .up(1'b1), .load(1'b0),
    .load_val(4'd0), .out(lo), .tc(lo_tc));
  sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RESET_VAL(0)) u_hi (
    .clk(clk), .rst(rst_c), .en(lo_tc), .up(1'b1), .load(1'b0),
    .load_val(4'd0), .out(hi), .tc(hi_tc));

  // Reference model: plain integers, one per configuration, plus the cascade as 0..99.
  int m_cnt [NI];
  bit m_vld [NI] = '{default: 1'b0};
  int c_cnt;
  bit c_vld = 1'b0;

  bit pin_on  [NI] = '{default: 1'b0};
  int pin_val [NI];
  bit cpin_on = 1'b0;
  int cpin_val;

  int tests = 0;
  int fails = 0;

  function automatic int dut_out(int i);
    case (i)
      0:       return int'(o0);
      1:       return int'(o1);
      2:       return int'(o2);
      default: return int'(o3);
    endcase
  endfunction

  function automatic int m_next(int i, int cur);
    int lv;
    int m;
    lv = int'(lv_s[i]) % (1 << WS[i]);
    m  = MODS[i];
    if (rst_s[i]) return RVS[i];
    if (ld_s[i])  return (lv < m) ? lv : m - 1;
    if (!en_s[i]) return cur;
    if (up_s[i])  return (cur == m - 1) ? ((SATS[i] != 0) ? cur : 0) : cur + 1;
    return (cur == 0) ? ((SATS[i] != 0) ? 0 : m - 1) : cur - 1;
  endfunction

  function automatic int m_tc(int i, int cur);
    if (rst_s[i] || ld_s[i] || !en_s[i]) return 0;
    if (up_s[i]) return (cur == MODS[i] - 1) ? 1 : 0;
    return (cur == 0) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      m_cnt[i] <= m_next(i, m_cnt[i]);
      if (rst_s[i]) m_vld[i] <= 1'b1;
    end
    if (rst_c)     c_cnt <= 0;
    else if (en_c) c_cnt <= (c_cnt + 1) % 100;
    if (rst_c) c_vld <= 1'b1;
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (m_vld[i]) begin
        chk($sformatf("out[%0d]", i), dut_out(i), m_cnt[i]);
        chk($sformatf("tc[%0d]", i), int'(tc_s[i]), m_tc(i, m_cnt[i]));
      end
      if (pin_on[i]) chk($sformatf("pin_out[%0d]", i), dut_out(i), pin_val[i]);
    end
    if (c_vld) begin
      chk("cascade_val", int'(hi) * 10 + int'(lo), c_cnt);
      chk("cascade_tc", int'(hi_tc), (en_c && !rst_c && c_cnt == 99) ? 1 : 0);
    end
    if (cpin_on) chk("pin_cascade", int'(hi) * 10 + int'(lo), cpin_val);
  end

  task automatic tick();
    @(posedge clk);
    #2;
    for (int i = 0; i < NI; i++) pin_on[i] = 1'b0;
    cpin_on = 1'b0;
  endtask

  task automatic pin(input int i, input int v);
    pin_on[i]  = 1'b1;
    pin_val[i] = v;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst_s[i] = 1'b1; en_s[i] = 1'b0; up_s[i] = 1'b0; ld_s[i] = 1'b0; lv_s[i] = 8'd0;
    end
    rst_c = 1'b1;
    en_c  = 1'b0;
    tick();
    for (int i = 0; i < NI; i++) pin(i, RVS[i]);

    for (int i = 0; i < NI; i++) rst_s[i] = 1'b0;
    rst_c = 1'b0;
    en_c  = 1'b1;
    en_s[0] = 1'b1; up_s[0] = 1'b0;
    en_s[1] = 1'b1; up_s[1] = 1'b1;
    en_s[2] = 1'b1; up_s[2] = 1'b1;

    for (int k = 1; k <= 100; k++) begin
      tick();
      case (k)
        9:  pin(1, 9);
        10: begin pin(1, 0); ld_s[1] = 1'b1; lv_s[1] = 8'd12; end
        11: begin pin(1, 9); ld_s[1] = 1'b0; en_s[1] = 1'b0; end
        12: begin pin(2, 9); up_s[2] = 1'b0; end
        16: pin(0, 0);
        17: begin
          pin(0, 15); pin(2, 4);
          ld_s[3] = 1'b1; lv_s[3] = 8'd5; en_s[3] = 1'b1; up_s[3] = 1'b1;
        end
        18: begin pin(3, 5); rst_s[3] = 1'b1; end
        19: begin pin(3, 200); rst_s[3] = 1'b0; ld_s[3] = 1'b0; en_s[3] = 1'b0; end
        24: begin pin(3, 200); ld_s[3] = 1'b1; lv_s[3] = 8'd255; end
        25: begin pin(3, 255); ld_s[3] = 1'b0; en_s[3] = 1'b1; up_s[3] = 1'b1; end
        26: begin pin(3, 0); en_s[3] = 1'b0; end
        99: begin cpin_on = 1'b1; cpin_val = 99; end
        100: begin cpin_on = 1'b1; cpin_val = 0; end
        default: ;
      endcase
      if (k >= 20 && k <= 23) begin
        pin(3, 200);
        up_s[3] = ~up_s[3];
      end
    end

    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < NI; i++) begin
        rst_s[i] = ($urandom_range(15) == 0);
        ld_s[i]  = ($urandom_range(7) == 0);
        en_s[i]  = ($urandom_range(3) != 0);
        up_s[i]  = 1'($urandom_range(1));
        lv_s[i]  = 8'($urandom_range(255));
      end
      rst_c = ($urandom_range(63) == 0);
      en_c  = ($urandom_range(3) != 0);
      tick();
    end

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
